// File: rtl/ahblite_timer_if.sv
// AHB-lite slave-side bus bundle for the timer peripheral.
// The master modport is the bus/decoder side; the slave modport is the peripheral.
interface ahblite_timer_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [3:0]  HPROT;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HSIZE, HPROT, HWRITE, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HSIZE, HPROT, HWRITE, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahblite_timer.sv
// AHB-lite timer: 32-bit reloading down-counter behind a prescaler, with a
// W1C interrupt flag gated by IE onto a level IRQ. Zero-wait-state slave.
module ahblite_timer #(
    parameter int          PRESC_W    = 8,
    parameter logic [31:0] RESET_LOAD = 32'h0000_0000
) (
    input  logic          HCLK,
    input  logic          HRESET,
    ahblite_timer_if.slave bus,
    output logic          TIMER_IRQ
);
    localparam logic [1:0] A_CTRL    = 2'd0;
    localparam logic [1:0] A_LOAD    = 2'd1;
    localparam logic [1:0] A_VALUE   = 2'd2;
    localparam logic [1:0] A_INTSTAT = 2'd3;

    logic [1:0]         addr_reg;
    logic               wr_reg;
    logic               valid_reg;
    logic               en_reg;
    logic               ie_reg;
    logic [PRESC_W-1:0] presc_reg;
    logic [PRESC_W-1:0] pcnt_reg;
    logic [31:0]        load_reg;
    logic [31:0]        value_reg;
    logic               int_reg;

    logic               addr_hit;
    logic               wr_active;
    logic [3:0]         wr_sel;
    logic               tick;
    logic [31:0]        ctrl_word;
    logic [31:0]        rd_mux;
    logic               unused_bits;

    assign addr_hit  = bus.HSEL & bus.HTRANS[1] & bus.HREADY;
    assign wr_active = valid_reg & wr_reg;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_wr_sel
            assign wr_sel[gi] = wr_active && (addr_reg == 2'(gi));
        end
    endgenerate

    assign tick = en_reg && (pcnt_reg == presc_reg);

    // Address phase: a low HREADY means another slave is stretching the bus.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            addr_reg  <= 2'd0;
            wr_reg    <= 1'b0;
            valid_reg <= 1'b0;
        end else if (bus.HREADY) begin
            valid_reg <= addr_hit;
            if (addr_hit) begin
                addr_reg <= bus.HADDR[3:2];
                wr_reg   <= bus.HWRITE;
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            en_reg    <= 1'b0;
            ie_reg    <= 1'b0;
            presc_reg <= '0;
            pcnt_reg  <= '0;
        end else begin
            if (wr_sel[A_CTRL]) begin
                en_reg    <= bus.HWDATA[0];
                ie_reg    <= bus.HWDATA[1];
                presc_reg <= bus.HWDATA[8 +: PRESC_W];
            end
            // Held at zero while disabled so re-enabling starts a full period.
            if (!en_reg || tick) begin
                pcnt_reg <= '0;
            end else begin
                pcnt_reg <= pcnt_reg + PRESC_W'(1);
            end
        end
    end

    // A LOAD write also lands in VALUE and beats any tick on the same edge.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            load_reg  <= RESET_LOAD;
            value_reg <= RESET_LOAD;
        end else begin
            if (wr_sel[A_LOAD]) begin
                load_reg  <= bus.HWDATA;
                value_reg <= bus.HWDATA;
            end else if (tick) begin
                value_reg <= (value_reg == 32'd0) ? load_reg : value_reg - 32'd1;
            end
        end
    end

    // Setting on a reload takes priority over a simultaneous W1C.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            int_reg <= 1'b0;
        end else if (tick && (value_reg == 32'd0)) begin
            int_reg <= 1'b1;
        end else if (wr_sel[A_INTSTAT] && bus.HWDATA[0]) begin
            int_reg <= 1'b0;
        end
    end

    always_comb begin
        ctrl_word                 = '0;
        ctrl_word[0]              = en_reg;
        ctrl_word[1]              = ie_reg;
        ctrl_word[8 +: PRESC_W]   = presc_reg;
        rd_mux                    = '0;
        case (addr_reg)
            A_CTRL:    rd_mux = ctrl_word;
            A_LOAD:    rd_mux = load_reg;
            A_VALUE:   rd_mux = value_reg;
            A_INTSTAT: rd_mux = {31'd0, int_reg};
            default:   rd_mux = '0;
        endcase
    end

    assign bus.HRDATA    = (valid_reg && !wr_reg) ? rd_mux : 32'd0;
    assign bus.HREADYOUT = 1'b1;
    assign bus.HRESP     = 1'b0;
    assign TIMER_IRQ     = int_reg & ie_reg;

    assign unused_bits = ^{bus.HSIZE, bus.HPROT, bus.HADDR[31:4], bus.HADDR[1:0],
                           bus.HTRANS[0], bus.HWDATA[31:8+PRESC_W], bus.HWDATA[7:2]};
endmodule

// File: tb/tb_ahblite_timer.sv
// Bench for ahblite_timer: directed scenarios plus random bus traffic, checked
// against an analytic model (tick counts from enable time, not per-cycle state).
module tb_ahblite_timer;
    logic HCLK = 1'b0;
    logic HRESET = 1'b1;
    logic TIMER_IRQ;

    ahblite_timer_if bus();

    ahblite_timer #(.PRESC_W(8), .RESET_LOAD(32'h0)) dut (
        .HCLK(HCLK),
        .HRESET(HRESET),
        .bus(bus.slave),
        .TIMER_IRQ(TIMER_IRQ)
    );

    always #5 HCLK = ~HCLK;

    longint cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    // Model: state anchored at edge m_a; ticks counted from the enable edge m_e0.
    bit     m_en, m_ie, m_i0;
    int     m_presc;
    longint m_load, m_v0, m_a, m_e0;

    bit          pend_v, pend_w;
    int          pend_a;
    logic [31:0] pend_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic longint ticks_upto(longint c);
        if (!m_en || c <= m_e0) return 0;
        return (c - m_e0) / (m_presc + 1);
    endfunction

    function automatic longint ticks_since(longint c);
        return ticks_upto(c) - ticks_upto(m_a);
    endfunction

    function automatic longint val_at(longint c);
        longint n;
        n = ticks_since(c);
        if (n <= m_v0) return m_v0 - n;
        return m_load - ((n - m_v0 - 1) % (m_load + 1));
    endfunction

    function automatic bit int_at(longint c);
        return m_i0 || (ticks_since(c) > m_v0);
    endfunction

    function automatic logic [31:0] reg_at(int idx, longint c);
        logic [31:0] r;
        r = '0;
        case (idx)
            0: begin r[0] = m_en; r[1] = m_ie; r[15:8] = 8'(m_presc); end
            1: r = 32'(m_load);
            2: r = 32'(val_at(c));
            default: r[0] = int_at(c);
        endcase
        return r;
    endfunction

    task automatic apply_write(input longint e, input int idx, input logic [31:0] wd);
        longint v_prev, v;
        bit tk, i, iset;
        v_prev = val_at(e - 1);
        tk     = (ticks_upto(e) - ticks_upto(e - 1)) != 0;
        v      = val_at(e);
        i      = int_at(e);
        iset   = tk && (v_prev == 0);
        case (idx)
            0: begin
                if (wd[0] && !m_en) m_e0 = e;
                m_en    = wd[0];
                m_ie    = wd[1];
                m_presc = int'(wd[15:8]);
            end
            1: begin m_load = longint'(wd); v = longint'(wd); end
            3: if (wd[0] && !iset) i = 1'b0;
            default: ;
        endcase
        m_v0 = v;
        m_i0 = i;
        m_a  = e;
    endtask

    task automatic model_reset();
        m_en = 0; m_ie = 0; m_presc = 0; m_load = 0; m_v0 = 0; m_i0 = 0;
        m_a = cyc; m_e0 = 0;
        pend_v = 0; pend_w = 0; pend_a = 0; pend_wdata = '0;
    endtask

    // One bus cycle: new address phase plus data phase of the pending transfer.
    task automatic step(input bit sel, input bit trans, input bit wr,
                        input logic [31:0] addr, input logic [31:0] wdata, input bit rdy);
        bus.HSEL   = sel;
        bus.HTRANS = trans ? 2'b10 : 2'b00;
        bus.HWRITE = wr;
        bus.HADDR  = addr;
        bus.HREADY = rdy;
        bus.HWDATA = pend_wdata;
        bus.HSIZE  = 3'b010;
        bus.HPROT  = 4'($urandom);
        #1;
        chk("hrdata", bus.HRDATA, (pend_v && !pend_w) ? reg_at(pend_a, cyc) : 32'h0);
        chk("irq", 32'(TIMER_IRQ), 32'(int_at(cyc) && m_ie));
        @(posedge HCLK);
        #1;
        if (pend_v && pend_w) apply_write(cyc, pend_a, pend_wdata);
        if (rdy) begin
            pend_v     = sel && trans;
            pend_w     = wr;
            pend_a     = int'(addr[3:2]);
            pend_wdata = wdata;
        end
    endtask

    task automatic wr(input int idx, input logic [31:0] d);
        step(1, 1, 1, {28'($urandom), 2'(idx), 2'b00}, d, 1);
    endtask

    task automatic rd(input int idx);
        step(1, 1, 0, {28'($urandom), 2'(idx), 2'b00}, 32'h0, 1);
    endtask

    task automatic idle();
        step(0, 0, 0, 32'h0, 32'h0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        longint e_en, v_before;
        bit found;
        bit eff_en;
        bus.HSEL = 0; bus.HADDR = 0; bus.HTRANS = 0; bus.HSIZE = 3'b010;
        bus.HPROT = 0; bus.HWRITE = 0; bus.HWDATA = 0; bus.HREADY = 1;
        model_reset();

        // Reset state
        HRESET = 1'b1;
        repeat (3) @(posedge HCLK);
        #1;
        chk("rst_readyout", 32'(bus.HREADYOUT), 32'h1);
        chk("rst_resp", 32'(bus.HRESP), 32'h0);
        chk("rst_irq", 32'(TIMER_IRQ), 32'h0);
        chk("rst_hrdata", bus.HRDATA, 32'h0);
        HRESET = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) rd(i);
        idle();

        // LOAD=5, PRESC=0, EN+IE: reload and IRQ six edges after enable
        wr(1, 32'd5);
        wr(0, 32'h3);
        e_en = cyc + 1;
        for (int k = 0; k < 10; k++) begin
            rd(2);
            if (cyc == e_en + 3) chk("value_mid", bus.HRDATA, 32'd2);
            if (cyc == e_en + 5) chk("irq_before_reload", 32'(TIMER_IRQ), 32'h0);
            if (cyc == e_en + 6) chk("irq_on_reload", 32'(TIMER_IRQ), 32'h1);
        end

        // PRESC=3, LOAD=2: INT 12 edges after enable
        wr(0, 32'h0);
        wr(3, 32'h1);
        wr(1, 32'd2);
        wr(0, 32'h303);
        e_en = cyc + 1;
        for (int k = 0; k < 16; k++) begin
            rd(2);
            if (cyc == e_en + 4) chk("presc_value", bus.HRDATA, 32'd1);
            if (cyc == e_en + 11) chk("presc_irq_before", 32'(TIMER_IRQ), 32'h0);
            if (cyc == e_en + 12) chk("presc_irq_set", 32'(TIMER_IRQ), 32'h1);
        end

        // W1C landing on a reload edge: set wins
        idle();
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            if ((ticks_upto(cyc + 2) - ticks_upto(cyc + 1)) == 1 && val_at(cyc + 1) == 0)
                found = 1;
            else
                idle();
        end
        chk("find_reload", 32'(found), 32'h1);
        wr(3, 32'h1);
        idle();
        chk("w1c_vs_set", 32'(TIMER_IRQ), 32'h1);
        // W1C with counting stopped: clears
        wr(0, 32'h302);
        wr(3, 32'h1);
        idle();
        chk("w1c_clear", 32'(TIMER_IRQ), 32'h0);
        rd(3);
        idle();

        // HREADY stretched by another slave during a VALUE read data phase
        wr(1, 32'd7);
        wr(0, 32'h1);
        idle();
        idle();
        rd(2);
        for (int k = 0; k < 3; k++) step(1, 1, 0, 32'h4, 32'h0, 0);
        idle();

        // VALUE is read-only; unselected / idle transfers return zero
        wr(0, 32'h0);
        idle();
        v_before = val_at(cyc);
        wr(2, 32'hDEADBEEF);
        idle();
        rd(2);
        chk("value_ro", bus.HRDATA, 32'(v_before));
        step(0, 1, 0, 32'h8, 32'h0, 1);
        chk("sel0_zero", bus.HRDATA, 32'h0);
        step(1, 0, 0, 32'h8, 32'h0, 1);
        chk("idle_zero", bus.HRDATA, 32'h0);
        idle();

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            int idx;
            bit w, v;
            logic [31:0] d;
            idx = $urandom_range(0, 3);
            w   = 1'($urandom_range(0, 1));
            v   = $urandom_range(0, 4) != 0;
            d   = $urandom;
            if (idx == 0) begin
                eff_en = (pend_v && pend_w && pend_a == 0) ? pend_wdata[0] : m_en;
                if (eff_en) d[0] = 1'b0;
                else d[15:8] = 8'($urandom_range(0, 3));
            end
            if (idx == 1) d = $urandom_range(0, 9);
            step(v, v, w, {28'($urandom), 2'(idx), 2'b00}, d, 1);
            if (i % 100 == 0) begin
                chk("readyout", 32'(bus.HREADYOUT), 32'h1);
                chk("resp", 32'(bus.HRESP), 32'h0);
            end
        end
        idle();

        // Asynchronous reset in the middle of a write data phase
        wr(1, 32'h55);
        HRESET = 1'b1;
        #2;
        chk("arst_readyout", 32'(bus.HREADYOUT), 32'h1);
        chk("arst_resp", 32'(bus.HRESP), 32'h0);
        chk("arst_irq", 32'(TIMER_IRQ), 32'h0);
        chk("arst_hrdata", bus.HRDATA, 32'h0);
        #1;
        HRESET = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) rd(i);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
